// File: rtl/rtc_pkg.sv
// Shared RTC definitions: responder register map, command op-codes and the
// bus-master FSM state encoding.
package rtc_pkg;

   localparam logic [2:0] ADDR_CLOCK       = 3'd0;
   localparam logic [2:0] ADDR_TIMER       = 3'd1;
   localparam logic [2:0] ADDR_STOPWATCH   = 3'd2;
   localparam logic [2:0] ADDR_ALARM       = 3'd3;
   localparam logic [2:0] ADDR_SPEED       = 3'd4;
   localparam logic [2:0] ADDR_HACK_TIME   = 3'd5;
   localparam logic [2:0] ADDR_HACK_CNT_HI = 3'd6;
   localparam logic [2:0] ADDR_HACK_CNT_LO = 3'd7;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_HACK  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [3:0] {
      ST_IDLE, ST_WRITE, ST_RD_ADDR, ST_RD_CAP, ST_HACK, ST_HWAIT,
      ST_H5, ST_H6, ST_H7, ST_HCAP, ST_RESP
   } state_e;

endpackage

// File: rtl/rtc_bus_master.sv
// Command-driven Wishbone initiator for the RTC: single writes, single reads,
// and the hack sequence (strobe, wait, pipelined read of registers 5..7).
module rtc_bus_master
   import rtc_pkg::*;
#(
   parameter int HACK_WAIT = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [1:0]  i_cmd_op,
   input  logic [2:0]  i_cmd_addr,
   input  logic [31:0] i_cmd_data,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [2:0]  o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic [31:0] i_wb_data,
   output logic        o_hack,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_data,
   output logic [29:0] o_rsp_hack_time,
   output logic [39:0] o_rsp_hack_counter,
   output logic        o_rsp_is_hack
);

   localparam logic [1:0] WAIT_LAST = 2'(HACK_WAIT - 1);

   state_e      state_q, state_d;
   logic [1:0]  wait_q;
   logic [2:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rsp_data_q;
   logic [29:0] hack_time_q;
   logic [39:0] hack_cnt_q;
   logic        is_hack_q;
   logic        accept;

   assign accept = i_cmd_valid && o_cmd_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (i_cmd_op)
                  OP_WRITE: state_d = ST_WRITE;
                  OP_HACK:  state_d = ST_HACK;
                  default:  state_d = ST_RD_ADDR;
               endcase
            end
         end
         ST_WRITE:   state_d = ST_IDLE;
         ST_RD_ADDR: state_d = ST_RD_CAP;
         ST_RD_CAP:  state_d = ST_RESP;
         ST_HACK:    state_d = ST_HWAIT;
         ST_HWAIT:   if (wait_q == WAIT_LAST) state_d = ST_H5;
         ST_H5:      state_d = ST_H6;
         ST_H6:      state_d = ST_H7;
         ST_H7:      state_d = ST_HCAP;
         ST_HCAP:    state_d = ST_RESP;
         ST_RESP:    if (i_rsp_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_wb_cyc    = 1'b0;
      o_wb_stb    = 1'b0;
      o_wb_we     = 1'b0;
      o_wb_addr   = addr_q;
      o_hack      = 1'b0;
      o_rsp_valid = 1'b0;
      o_cmd_ready = 1'b0;
      case (state_q)
         ST_IDLE:    o_cmd_ready = 1'b1;
         ST_WRITE:   begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; o_wb_we = 1'b1; end
         ST_RD_ADDR: begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; end
         ST_HACK:    o_hack = 1'b1;
         ST_H5:      begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; o_wb_addr = ADDR_HACK_TIME;   end
         ST_H6:      begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; o_wb_addr = ADDR_HACK_CNT_HI; end
         ST_H7:      begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; o_wb_addr = ADDR_HACK_CNT_LO; end
         ST_RESP:    o_rsp_valid = 1'b1;
         default:    ;
      endcase
   end

   // Read data trails its address by one cycle, so each capture state
   // samples the word addressed in the state before it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wait_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         hack_time_q <= '0;
         hack_cnt_q  <= '0;
         is_hack_q   <= 1'b0;
      end else begin
         wait_q <= (state_q == ST_HWAIT) ? wait_q + 2'd1 : 2'd0;
         if (accept) begin
            is_hack_q <= (i_cmd_op == OP_HACK);
            if (i_cmd_op != OP_HACK)  addr_q  <= i_cmd_addr;
            if (i_cmd_op == OP_WRITE) wdata_q <= i_cmd_data;
         end
         case (state_q)
            ST_RD_CAP: rsp_data_q        <= i_wb_data;
            ST_H6:     hack_time_q       <= i_wb_data[29:0];
            ST_H7:     hack_cnt_q[39:8]  <= i_wb_data;
            ST_HCAP:   hack_cnt_q[7:0]   <= i_wb_data[31:24];
            default:   ;
         endcase
      end
   end

   assign o_wb_data          = wdata_q;
   assign o_rsp_data         = rsp_data_q;
   assign o_rsp_hack_time    = hack_time_q;
   assign o_rsp_hack_counter = hack_cnt_q;
   assign o_rsp_is_hack      = is_hack_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master: table of commands with expected bus
// timing and response contents, plus stall, reset-abort and reset-vs-command cases.
module tb_rtc_bus_master;
   import rtc_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic [1:0]  i_cmd_op = 2'd0;
   logic [2:0]  i_cmd_addr = 3'd0;
   logic [31:0] i_cmd_data = 32'd0;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [2:0]  o_wb_addr;
   logic [31:0] o_wb_data;
   logic [31:0] i_wb_data;
   logic        o_hack;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_data;
   logic [29:0] o_rsp_hack_time;
   logic [39:0] o_rsp_hack_counter;
   logic        o_rsp_is_hack;

   int checks = 0;
   int errors = 0;

   rtc_bus_master #(.HACK_WAIT(1)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_op(i_cmd_op), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_data(i_wb_data),
      .o_hack(o_hack), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_hack_time(o_rsp_hack_time),
      .o_rsp_hack_counter(o_rsp_hack_counter), .o_rsp_is_hack(o_rsp_is_hack)
   );

   always #5 i_clk = ~i_clk;

   // Responder model: read data appears the cycle after the address cycle.
   logic [31:0] mem [8];
   always @(posedge i_clk) begin
      if (i_reset) begin
         mem[0] <= 32'h11110000; mem[1] <= 32'h22220000;
         mem[2] <= 32'h00123401; mem[3] <= 32'h33330000;
         mem[4] <= 32'h00000000; mem[5] <= 32'h01234567;
         mem[6] <= 32'hAABBCCDD; mem[7] <= 32'hEE000000;
         i_wb_data <= 32'd0;
      end else if (o_wb_cyc && o_wb_stb) begin
         if (o_wb_we) mem[o_wb_addr] <= o_wb_data;
         else         i_wb_data <= mem[o_wb_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  addr;
      logic [31:0] data;
      int          hack_k;
      int          stb_k;
      logic [2:0]  stb_addr;
      int          stb_n;
      int          we_n;
      int          ready_k;
      int          valid_k;
      logic [31:0] exp_data;
      logic        exp_is_hack;
      logic [29:0] exp_time;
      logic [39:0] exp_cnt;
   } vec_t;

   vec_t vecs [7];

   // Called at a negedge with the DUT idle; returns at a negedge with it idle.
   task automatic run_vec(input string tag, input vec_t v);
      int hk, sk, sn, wn, rk, vk, cycbad;
      logic [2:0]  sa;
      logic [31:0] wd;
      hk = 0; sk = 0; sn = 0; wn = 0; rk = 0; vk = 0; cycbad = 0; sa = 0; wd = 0;
      i_cmd_valid = 1'b1; i_cmd_op = v.op; i_cmd_addr = v.addr; i_cmd_data = v.data;
      chk({tag, "_ready_at_issue"}, 64'(o_cmd_ready), 64'd1);
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (o_hack) begin hk = (hk == 0) ? k : -1; end
         if (o_wb_stb) begin
            sn++;
            if (sk == 0) begin sk = k; sa = o_wb_addr; wd = o_wb_data; end
         end
         if (o_wb_we) wn++;
         if (o_wb_cyc != o_wb_stb) cycbad++;
         if (o_cmd_ready && rk == 0) rk = k;
         if (o_rsp_valid) begin vk = k; break; end
         @(negedge i_clk);
      end
      chk({tag, "_hack_cycle"}, 64'(hk), 64'(v.hack_k));
      chk({tag, "_stb_cycle"}, 64'(sk), 64'(v.stb_k));
      chk({tag, "_stb_addr"}, 64'(sa), 64'(v.stb_addr));
      chk({tag, "_stb_count"}, 64'(sn), 64'(v.stb_n));
      chk({tag, "_we_count"}, 64'(wn), 64'(v.we_n));
      chk({tag, "_cyc_eq_stb"}, 64'(cycbad), 64'd0);
      chk({tag, "_ready_cycle"}, 64'(rk), 64'(v.ready_k));
      chk({tag, "_valid_cycle"}, 64'(vk), 64'(v.valid_k));
      if (v.op == OP_WRITE) chk({tag, "_wb_wdata"}, 64'(wd), 64'(v.exp_data));
      if (vk != 0) begin
         chk({tag, "_is_hack"}, 64'(o_rsp_is_hack), 64'(v.exp_is_hack));
         if (v.exp_is_hack) begin
            chk({tag, "_hack_time"}, 64'(o_rsp_hack_time), 64'(v.exp_time));
            chk({tag, "_hack_cnt"}, 64'(o_rsp_hack_counter), 64'(v.exp_cnt));
         end else begin
            chk({tag, "_rsp_data"}, 64'(o_rsp_data), 64'(v.exp_data));
         end
         i_rsp_ready = 1'b1;
         @(negedge i_clk);
         i_rsp_ready = 1'b0;
         chk({tag, "_valid_after_hs"}, 64'(o_rsp_valid), 64'd0);
         chk({tag, "_ready_after_hs"}, 64'(o_cmd_ready), 64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int vk, bad;
      vec_t rv;
      //            op        addr  data           hk sk sa  sn wn rk vk exp_data        ish time          cnt
      vecs[0] = '{OP_WRITE, 3'd4, 32'd2814750,  0, 1, 3'd4, 1, 1, 2, 0, 32'd2814750,  1'b0, 30'd0, 40'd0};
      vecs[1] = '{OP_READ,  3'd2, 32'd0,        0, 1, 3'd2, 1, 0, 0, 3, 32'h00123401, 1'b0, 30'd0, 40'd0};
      vecs[2] = '{OP_HACK,  3'd0, 32'd0,        1, 3, 3'd5, 3, 0, 0, 7, 32'd0,        1'b1, 30'h01234567, 40'hAABBCCDDEE};
      vecs[3] = '{OP_RSVD,  3'd4, 32'd0,        0, 1, 3'd4, 1, 0, 0, 3, 32'd2814750,  1'b0, 30'd0, 40'd0};
      vecs[4] = '{OP_WRITE, 3'd1, 32'hDEADBEEF, 0, 1, 3'd1, 1, 1, 2, 0, 32'hDEADBEEF, 1'b0, 30'd0, 40'd0};
      vecs[5] = '{OP_READ,  3'd1, 32'd0,        0, 1, 3'd1, 1, 0, 0, 3, 32'hDEADBEEF, 1'b0, 30'd0, 40'd0};
      vecs[6] = '{OP_READ,  3'd7, 32'd0,        0, 1, 3'd7, 1, 0, 0, 3, 32'hEE000000, 1'b0, 30'd0, 40'd0};

      // Reset state, with a command offered during reset that must not start.
      @(negedge i_clk);
      i_cmd_valid = 1'b1; i_cmd_op = OP_WRITE; i_cmd_addr = 3'd3; i_cmd_data = 32'h77;
      @(negedge i_clk);
      chk("rst_cyc", 64'(o_wb_cyc), 64'd0);
      chk("rst_stb", 64'(o_wb_stb), 64'd0);
      chk("rst_we", 64'(o_wb_we), 64'd0);
      chk("rst_addr", 64'(o_wb_addr), 64'd0);
      chk("rst_wdata", 64'(o_wb_data), 64'd0);
      chk("rst_hack", 64'(o_hack), 64'd0);
      chk("rst_valid", 64'(o_rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(o_rsp_data), 64'd0);
      chk("rst_time", 64'(o_rsp_hack_time), 64'd0);
      chk("rst_cnt", 64'(o_rsp_hack_counter), 64'd0);
      chk("rst_is_hack", 64'(o_rsp_is_hack), 64'd0);
      i_reset = 1'b0; i_cmd_valid = 1'b0;
      @(negedge i_clk);
      chk("rst_cmd_ignored_cyc", 64'(o_wb_cyc), 64'd0);
      chk("ready_after_reset", 64'(o_cmd_ready), 64'd1);

      for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // Response back-pressure: held response, no new command taken.
      i_cmd_valid = 1'b1; i_cmd_op = OP_READ; i_cmd_addr = 3'd2;
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      vk = 0;
      for (int k = 1; k <= 6 && vk == 0; k++) begin
         if (o_rsp_valid) vk = k; else @(negedge i_clk);
      end
      chk("stall_valid_cycle", 64'(vk), 64'd3);
      i_cmd_valid = 1'b1; i_cmd_op = OP_WRITE; i_cmd_addr = 3'd0; i_cmd_data = 32'h55;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("stall%0d_valid", k), 64'(o_rsp_valid), 64'd1);
         chk($sformatf("stall%0d_data", k), 64'(o_rsp_data), 64'h00123401);
         chk($sformatf("stall%0d_ready", k), 64'(o_cmd_ready), 64'd0);
         chk($sformatf("stall%0d_cyc", k), 64'(o_wb_cyc), 64'd0);
         @(negedge i_clk);
      end
      i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      chk("stall_valid_after_hs", 64'(o_rsp_valid), 64'd0);
      rv = '{OP_READ, 3'd0, 32'd0, 0, 1, 3'd0, 1, 0, 0, 3, 32'h11110000, 1'b0, 30'd0, 40'd0};
      run_vec("stall_no_write", rv);

      // Reset during H6 aborts the hack sequence.
      i_cmd_valid = 1'b1; i_cmd_op = OP_HACK;
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      chk("abort_hack_strobe", 64'(o_hack), 64'd1);
      repeat (3) @(negedge i_clk);
      chk("abort_in_h6_addr", 64'(o_wb_addr), 64'd6);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("abort_cyc", 64'(o_wb_cyc), 64'd0);
      chk("abort_stb", 64'(o_wb_stb), 64'd0);
      chk("abort_addr", 64'(o_wb_addr), 64'd0);
      chk("abort_wdata", 64'(o_wb_data), 64'd0);
      chk("abort_valid", 64'(o_rsp_valid), 64'd0);
      chk("abort_rsp_data", 64'(o_rsp_data), 64'd0);
      chk("abort_time", 64'(o_rsp_hack_time), 64'd0);
      chk("abort_cnt", 64'(o_rsp_hack_counter), 64'd0);
      chk("abort_is_hack", 64'(o_rsp_is_hack), 64'd0);
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("abort_ready", 64'(o_cmd_ready), 64'd1);
      bad = 0;
      repeat (8) begin
         if (o_rsp_valid || o_wb_stb || o_hack) bad++;
         @(negedge i_clk);
      end
      chk("abort_quiet", 64'(bad), 64'd0);
      run_vec("post_abort_read", vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_bus_master.md
RTC_BUS_MASTER -- requirements
Module: rtc_bus_master

Interface
REQ-001 Parameter HACK_WAIT, default 1: idle cycles inserted between the o_hack pulse and the first hack-register read; legal range 1..3.
REQ-002 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_cmd_valid  in  1  command request.
REQ-005 o_cmd_ready  out  1  command accepted on i_cmd_valid && o_cmd_ready.
REQ-006 i_cmd_op  in  2  0=WRITE, 1=READ, 2=HACK, 3=reserved (treated as READ).
REQ-007 i_cmd_addr  in  3  target register address (WRITE/READ only).
REQ-008 i_cmd_data  in  32  write data (WRITE only).
REQ-009 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone initiator controls to the RTC responder.
REQ-010 o_wb_addr  out  3  register address; o_wb_data  out  32  write data.
REQ-011 i_wb_data  in  32  responder read data, valid one cycle after the address cycle; no ack is used.
REQ-012 o_hack  out  1  single-cycle time-capture strobe to the responder.
REQ-013 o_rsp_valid  out  1  response held until i_rsp_ready.
REQ-014 i_rsp_ready  in  1  response consumed on o_rsp_valid && i_rsp_ready.
REQ-015 o_rsp_data  out  32  READ result.
REQ-016 o_rsp_hack_time  out  30  captured {clock[21:0], subseconds[7:0]}.
REQ-017 o_rsp_hack_counter  out  40  captured fractional counter.
REQ-018 o_rsp_is_hack  out  1  response type: 1=HACK, 0=READ.

Function
REQ-019 FSM states: IDLE, WRITE, RD_ADDR, RD_CAP, HACK, HWAIT, H5, H6, H7, HCAP, RESP.
REQ-020 o_cmd_ready shall be 1 only in IDLE with o_rsp_valid low.
REQ-021 WRITE: one cycle with cyc=stb=we=1, addr/data from the command; returns to IDLE next cycle; no response.
REQ-022 READ: RD_ADDR drives cyc=stb=1, we=0, addr for one cycle; RD_CAP registers i_wb_data into o_rsp_data; then RESP.
REQ-023 HACK: o_hack=1 for exactly one cycle (cycle H); HWAIT lasts HACK_WAIT cycles; H5/H6/H7 drive addresses 5, 6, 7 on consecutive cycles with stb=1.
REQ-024 Hack capture pipelined: data for addr 5 sampled in H6, addr 6 in H7, addr 7 in HCAP; o_rsp_hack_time=word5[29:0], o_rsp_hack_counter={word6, word7[31:24]}.
REQ-025 With HACK_WAIT=1: o_hack in cycle H, addr 5 in H+2, o_rsp_valid asserted in H+6.
REQ-026 RESP: o_rsp_valid=1 and outputs stable until handshake; return to IDLE on the cycle after the handshake.
REQ-027 o_wb_cyc/o_wb_stb shall be 0 in IDLE, HACK, HWAIT, RD_CAP, HCAP, RESP; o_wb_we=1 only in WRITE.
REQ-028 A new command presented while busy shall not be accepted and must be held by the source.
REQ-029 Reserved op 3 shall behave exactly as READ.
REQ-030 o_rsp_* data registers are written only at capture; o_rsp_is_hack is set at command accept.

Reset
REQ-031 On i_reset: state=IDLE; o_wb_cyc=o_wb_stb=o_wb_we=0; o_wb_addr=0; o_wb_data=0; o_hack=0; o_rsp_valid=0; all o_rsp_* data=0.
REQ-032 Reset mid-transaction aborts it in the same cycle; no response is issued; o_cmd_ready=1 the cycle after reset deasserts.
REQ-033 Reset overrides a simultaneous command handshake or response handshake.

Structure
REQ-034 Shared package rtc_pkg holds register address constants (CLOCK=0, TIMER=1, STOPWATCH=2, ALARM=3, SPEED=4, HACK_TIME=5, HACK_CNT_HI=6, HACK_CNT_LO=7) and the op-code enumeration.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 WRITE addr 4, data 32'd2814750 -> one cycle stb=we=1, addr=4; no o_rsp_valid; ready=1 two cycles after accept.
REQ-037 READ addr 2, responder returns 32'h00123401 -> o_rsp_data=32'h00123401, o_rsp_is_hack=0, valid three cycles after accept.
REQ-038 HACK with words 5/6/7 = 30'h0123_4567, 32'hAABBCCDD, 32'hEE000000 -> hack_time=30'h01234567, counter=40'hAABBCCDDEE, valid at H+6.
REQ-039 i_rsp_ready held low 10 cycles -> response stable, o_cmd_ready=0, new commands not accepted.
REQ-040 i_reset asserted during H6 -> all outputs reset next cycle, no response, next READ completes normally.
